// File: rtl/render_rects_nested.sv
// render_rects_nested: draws a run of concentric rectangles, each inset by
// k*STEP from the outer box, with the colour index stepping once per shape.
// The rectangle engine is the render_rects_engine sub-module below. With FILL=0
// it draws the outline only. With FILL=1 it draws the whole area.
//
// Ports (render_rects_nested)
//   clk_i      clock
//   rst_i      synchronous reset, active high (also resets the engine)
//   oe_i       output enable; low freezes pixel output
//   start_i    start a run; only looked at in IDLE
//   x_o, y_o   signed draw position from the engine
//   cidx_o     colour index of the current shape
//   drawing_o  x_o/y_o/cidx_o valid this cycle
//   busy_o     run in progress
//   done_o     one-cycle pulse at the end of a run (never after an abort)

// Rectangle engine. It scans the box row by row. In outline mode an interior
// row emits only its two end pixels: after x0 it jumps straight to x1, so no
// cycles are spent on pixels that are never drawn.
// Ports: start_i loads the box. x0_i..y1_i must be held stable while busy.
// x_o/y_o/drawing_o give the pixel stream. done_o pulses one cycle after the
// last pixel.
module render_rects_engine #(
  parameter int CORDW = 16,
  parameter int FILL  = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    oe_i,
  input  logic signed [CORDW-1:0] x0_i,
  input  logic signed [CORDW-1:0] y0_i,
  input  logic signed [CORDW-1:0] x1_i,
  input  logic signed [CORDW-1:0] y1_i,
  output logic signed [CORDW-1:0] x_o,
  output logic signed [CORDW-1:0] y_o,
  output logic                    drawing_o,
  output logic                    busy_o,
  output logic                    done_o
);
  localparam logic signed [CORDW-1:0] ONE = CORDW'(1);

  logic signed [CORDW-1:0] x_q, x_d, y_q, y_d;
  logic busy_q, busy_d, done_q, done_d;
  logic last_x, edge_row;

  assign last_x    = (x_q == x1_i);
  assign edge_row  = (y_q == y0_i) || (y_q == y1_i);
  assign drawing_o = busy_q & oe_i;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign x_o       = x_q;
  assign y_o       = y_q;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      x_d    = x0_i;
      y_d    = y0_i;
      busy_d = 1'b1;
    end else if (busy_q && oe_i) begin
      if (last_x && y_q == y1_i) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else if (last_x) begin
        x_d = x0_i;
        y_d = y_q + ONE;
      end else if (FILL == 0 && !edge_row && x_q == x0_i) begin
        x_d = x1_i;
      end else begin
        x_d = x_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q    <= '0;
      y_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule

module render_rects_nested #(
  parameter int CORDW     = 16,
  parameter int CIDXW     = 4,
  parameter int SCALE     = 1,
  parameter int SHAPE_CNT = 64,
  parameter int STEP      = 1,
  parameter int X0        = 60,
  parameter int Y0        = 20,
  parameter int X1        = 260,
  parameter int Y1        = 160,
  parameter int FILL      = 0,
  parameter int CIDX_BASE = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    oe_i,
  input  logic                    start_i,
  output logic signed [CORDW-1:0] x_o,
  output logic signed [CORDW-1:0] y_o,
  output logic [CIDXW-1:0]        cidx_o,
  output logic                    drawing_o,
  output logic                    busy_o,
  output logic                    done_o
);
  localparam int SIDW = $clog2(SHAPE_CNT) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INIT = 2'd1;
  localparam logic [1:0] DRAW = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic signed [CORDW-1:0] X0_C    = CORDW'(X0);
  localparam logic signed [CORDW-1:0] Y0_C    = CORDW'(Y0);
  localparam logic signed [CORDW-1:0] X1_C    = CORDW'(X1);
  localparam logic signed [CORDW-1:0] Y1_C    = CORDW'(Y1);
  localparam logic signed [CORDW-1:0] STEP_C  = CORDW'(STEP);
  localparam logic signed [CORDW-1:0] SCALE_C = CORDW'(SCALE);

  logic [1:0]              state_q, state_d;
  logic [SIDW-1:0]         shape_id_q, shape_id_d;
  logic [CIDXW-1:0]        cidx_q, cidx_d;
  logic signed [CORDW-1:0] bx0_q, bx0_d, by0_q, by0_d, bx1_q, bx1_d, by1_q, by1_d;
  logic                    draw_start_q, draw_start_d;
  logic                    done_q, done_d;

  // Inset box for the current shape, still unscaled: the degenerate test
  // must see unscaled values.
  logic signed [CORDW-1:0] k_s, off, sx0, sy0, sx1, sy1;
  logic                    degen, eng_done;

  assign k_s   = CORDW'(shape_id_q);
  assign off   = k_s * STEP_C;
  assign sx0   = X0_C + off;
  assign sy0   = Y0_C + off;
  assign sx1   = X1_C - off;
  assign sy1   = Y1_C - off;
  assign degen = (sx0 > sx1) || (sy0 > sy1);

  always_comb begin
    state_d      = state_q;
    shape_id_d   = shape_id_q;
    cidx_d       = cidx_q;
    bx0_d        = bx0_q;
    by0_d        = by0_q;
    bx1_d        = bx1_q;
    by1_d        = by1_q;
    draw_start_d = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d    = INIT;
        shape_id_d = '0;
      end
      INIT: if (degen) begin
        state_d = DONE;
      end else begin
        bx0_d        = sx0 * SCALE_C;
        by0_d        = sy0 * SCALE_C;
        bx1_d        = sx1 * SCALE_C;
        by1_d        = sy1 * SCALE_C;
        cidx_d       = CIDXW'(CIDX_BASE) + CIDXW'(shape_id_q);  // wraps silently
        draw_start_d = 1'b1;
        state_d      = DRAW;
      end
      // The engine's done pulse from the previous shape has already cleared
      // by the time the next shape reaches DRAW, so it cannot be seen twice.
      DRAW: if (eng_done) begin
        if (shape_id_q == SIDW'(SHAPE_CNT - 1)) begin
          state_d = DONE;
        end else begin
          shape_id_d = shape_id_q + 1'b1;
          state_d    = INIT;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      shape_id_q   <= '0;
      cidx_q       <= '0;
      bx0_q        <= '0;
      by0_q        <= '0;
      bx1_q        <= '0;
      by1_q        <= '0;
      draw_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shape_id_q   <= shape_id_d;
      cidx_q       <= cidx_d;
      bx0_q        <= bx0_d;
      by0_q        <= by0_d;
      bx1_q        <= bx1_d;
      by1_q        <= by1_d;
      draw_start_q <= draw_start_d;
      done_q       <= done_d;
    end
  end

  logic eng_busy;

  render_rects_engine #(.CORDW(CORDW), .FILL(FILL)) u_engine (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (draw_start_q),
    .oe_i      (oe_i),
    .x0_i      (bx0_q),
    .y0_i      (by0_q),
    .x1_i      (bx1_q),
    .y1_i      (by1_q),
    .x_o       (x_o),
    .y_o       (y_o),
    .drawing_o (drawing_o),
    .busy_o    (eng_busy),
    .done_o    (eng_done)
  );

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign cidx_o = cidx_q;
endmodule

// File: tb/tb_render_rects_nested.sv
// Directed bench for render_rects_nested. It uses five instances that share
// clk and rst:
//   0 outline  box (0,0)-(7,5),  STEP 2, 4 shapes
//   1 filled   the same box and shapes
//   2 colour wrap: CIDXW 2, base 3, 3 shapes, box (0,0)-(20,20)
//   3 degenerate box (5,5)-(4,9)
//   4 outline  as instance 0, with SCALE 2
// Only one instance runs at a time. sel routes that instance's outputs to the m_* signals.
module tb_render_rects_nested;
  localparam int CW   = 16;
  localparam int MAXC = 3000;

  logic clk = 1'b0;
  logic rst;
  logic start_v [5];
  logic oe_v    [5];
  logic signed [CW-1:0] xs [5];
  logic signed [CW-1:0] ys [5];
  logic dr [5];
  logic bz [5];
  logic dn [5];
  logic [3:0] c0, c1, c3, c4;
  logic [1:0] c2;

  int sel;
  logic signed [CW-1:0] m_x, m_y;
  logic [3:0] m_c;
  logic m_dr, m_bz, m_dn;

  always #5 clk = ~clk;

  render_rects_nested #(.SHAPE_CNT(4), .STEP(2), .X0(0), .Y0(0), .X1(7), .Y1(5), .FILL(0)) dut_o (
    .clk_i(clk), .rst_i(rst), .oe_i(oe_v[0]), .start_i(start_v[0]), .x_o(xs[0]), .y_o(ys[0]),
    .cidx_o(c0), .drawing_o(dr[0]), .busy_o(bz[0]), .done_o(dn[0]));
  render_rects_nested #(.SHAPE_CNT(4), .STEP(2), .X0(0), .Y0(0), .X1(7), .Y1(5), .FILL(1)) dut_f (
    .clk_i(clk), .rst_i(rst), .oe_i(oe_v[1]), .start_i(start_v[1]), .x_o(xs[1]), .y_o(ys[1]),
    .cidx_o(c1), .drawing_o(dr[1]), .busy_o(bz[1]), .done_o(dn[1]));
  render_rects_nested #(.CIDXW(2), .CIDX_BASE(3), .SHAPE_CNT(3), .X0(0), .Y0(0), .X1(20), .Y1(20)) dut_c (
    .clk_i(clk), .rst_i(rst), .oe_i(oe_v[2]), .start_i(start_v[2]), .x_o(xs[2]), .y_o(ys[2]),
    .cidx_o(c2), .drawing_o(dr[2]), .busy_o(bz[2]), .done_o(dn[2]));
  render_rects_nested #(.X0(5), .Y0(5), .X1(4), .Y1(9)) dut_d (
    .clk_i(clk), .rst_i(rst), .oe_i(oe_v[3]), .start_i(start_v[3]), .x_o(xs[3]), .y_o(ys[3]),
    .cidx_o(c3), .drawing_o(dr[3]), .busy_o(bz[3]), .done_o(dn[3]));
  render_rects_nested #(.SCALE(2), .SHAPE_CNT(4), .STEP(2), .X0(0), .Y0(0), .X1(7), .Y1(5), .FILL(0)) dut_s (
    .clk_i(clk), .rst_i(rst), .oe_i(oe_v[4]), .start_i(start_v[4]), .x_o(xs[4]), .y_o(ys[4]),
    .cidx_o(c4), .drawing_o(dr[4]), .busy_o(bz[4]), .done_o(dn[4]));

  always_comb begin
    case (sel)
      0:       begin m_x = xs[0]; m_y = ys[0]; m_c = c0; m_dr = dr[0]; m_bz = bz[0]; m_dn = dn[0]; end
      1:       begin m_x = xs[1]; m_y = ys[1]; m_c = c1; m_dr = dr[1]; m_bz = bz[1]; m_dn = dn[1]; end
      2:       begin m_x = xs[2]; m_y = ys[2]; m_c = {2'b00, c2}; m_dr = dr[2]; m_bz = bz[2]; m_dn = dn[2]; end
      3:       begin m_x = xs[3]; m_y = ys[3]; m_c = c3; m_dr = dr[3]; m_bz = bz[3]; m_dn = dn[3]; end
      default: begin m_x = xs[4]; m_y = ys[4]; m_c = c4; m_dr = dr[4]; m_bz = bz[4]; m_dn = dn[4]; end
    endcase
  end

  int checks = 0;
  int errors = 0;

  // Results of the most recent run.
  int qx[$], qy[$], qc[$];
  int ndone, done_cyc, last_pix, first_busy, t1_done, t1_tot;
  bit tmo, busy_end;

  function automatic int distinct(input int c);
    bit seen [0:4095];
    int n = 0;
    for (int i = 0; i < 4096; i++) seen[i] = 1'b0;
    for (int i = 0; i < qx.size(); i++)
      if (qc[i] == c && !seen[(qx[i] & 63) * 64 + (qy[i] & 63)]) begin
        seen[(qx[i] & 63) * 64 + (qy[i] & 63)] = 1'b1;
        n++;
      end
    return n;
  endfunction

  function automatic int cntc(input int c);
    int n = 0;
    for (int i = 0; i < qx.size(); i++) if (qc[i] == c) n++;
    return n;
  endfunction

  // Pixels of colour c that fall outside the box. In outline mode, also those off its border.
  function automatic int outside(input int c, input int bx0, input int by0, input int bx1,
                                 input int by1, input bit outl);
    int n = 0;
    for (int i = 0; i < qx.size(); i++) if (qc[i] == c) begin
      if (!(qx[i] >= bx0 && qx[i] <= bx1 && qy[i] >= by0 && qy[i] <= by1) ||
          (outl && !(qx[i] == bx0 || qx[i] == bx1 || qy[i] == by0 || qy[i] == by1))) n++;
    end
    return n;
  endfunction

  function automatic int first_non(input int c, input int n);
    int k = 0;
    for (int i = 0; i < n && i < qx.size(); i++) if (qc[i] != c) k++;
    return k;
  endfunction

  // Starts instance s and records every drawn pixel until 4 cycles after the first done.
  // Cycle 0 is the first cycle after start is sampled.
  task automatic run(input int s, input int oe_pct, input int restart_at, input bit hold);
    qx.delete(); qy.delete(); qc.delete();
    ndone = 0; done_cyc = -1; last_pix = -1; first_busy = -1; tmo = 1'b1;
    sel = s;
    @(negedge clk); start_v[s] = 1'b1; oe_v[s] = 1'b1;
    for (int cyc = 0; cyc < MAXC; cyc++) begin
      @(negedge clk);
      start_v[s] = hold || (cyc == restart_at);
      oe_v[s] = ($urandom_range(99) < oe_pct);
      #1;
      if (m_dr) begin qx.push_back(int'(m_x)); qy.push_back(int'(m_y)); qc.push_back(int'(m_c)); last_pix = cyc; end
      if (m_bz && first_busy < 0) first_busy = cyc;
      if (m_dn) begin ndone++; if (done_cyc < 0) done_cyc = cyc; end
      busy_end = m_bz;
      if (done_cyc >= 0 && cyc >= done_cyc + 4) begin tmo = 1'b0; break; end
    end
    start_v[s] = 1'b0; oe_v[s] = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; sel = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (m_x !== 0 || m_y !== 0) begin errors++; $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", m_x, m_y); end
    checks++; if (m_c !== 0) begin errors++; $display("FAIL reset_cidx: got %0d want 0", m_c); end
    checks++; if ({m_dr, m_bz, m_dn} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {m_dr, m_bz, m_dn}); end
    sel = 2; #1;
    checks++; if (m_c !== 0) begin errors++; $display("FAIL reset_cidx_wrap: got %0d want 0", m_c); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_outline;
    run(0, 100, -1, 1'b0);
    t1_done = done_cyc; t1_tot = qx.size();
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL t1_timeout: got no done within %0d cycles", MAXC); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL t1_done_cnt: got %0d want 1", ndone); end
    checks++; if (distinct(0) !== 24) begin errors++; $display("FAIL t1_s0_pixels: got %0d want 24", distinct(0)); end
    checks++; if (outside(0, 0, 0, 7, 5, 1) !== 0) begin errors++; $display("FAIL t1_s0_border: got %0d stray want 0", outside(0, 0, 0, 7, 5, 1)); end
    checks++; if (distinct(1) !== 8) begin errors++; $display("FAIL t1_s1_pixels: got %0d want 8", distinct(1)); end
    checks++; if (outside(1, 2, 2, 5, 3, 1) !== 0) begin errors++; $display("FAIL t1_s1_border: got %0d stray want 0", outside(1, 2, 2, 5, 3, 1)); end
    checks++; if (qx.size() - cntc(0) - cntc(1) !== 0) begin errors++; $display("FAIL t1_extra_shape: got %0d pixels want 0", qx.size() - cntc(0) - cntc(1)); end
    checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL t1_busy_after: got %b want 0", busy_end); end
  endtask

  task automatic test_fill;
    run(1, 100, -1, 1'b0);
    checks++; if (tmo !== 1'b0 || ndone !== 1) begin errors++; $display("FAIL t2_done: got tmo=%0d ndone=%0d want 0,1", tmo, ndone); end
    checks++; if (qx.size() !== 56) begin errors++; $display("FAIL t2_total: got %0d want 56", qx.size()); end
    checks++; if (first_non(0, 48) !== 0) begin errors++; $display("FAIL t2_first48: got %0d non-cidx0 want 0", first_non(0, 48)); end
    checks++; if (distinct(0) !== 48 || cntc(1) !== 8) begin errors++; $display("FAIL t2_counts: got %0d/%0d want 48/8", distinct(0), cntc(1)); end
    checks++; if (outside(0, 0, 0, 7, 5, 0) + outside(1, 2, 2, 5, 3, 0) !== 0) begin
      errors++; $display("FAIL t2_inside: got %0d stray want 0", outside(0, 0, 0, 7, 5, 0) + outside(1, 2, 2, 5, 3, 0)); end
  endtask

  task automatic test_colour_wrap;
    run(2, 100, -1, 1'b0);
    checks++; if (tmo !== 1'b0 || ndone !== 1) begin errors++; $display("FAIL t3_done: got tmo=%0d ndone=%0d want 0,1", tmo, ndone); end
    checks++; if (distinct(3) !== 80 || distinct(0) !== 72 || distinct(1) !== 64) begin
      errors++; $display("FAIL t3_counts: got %0d/%0d/%0d want 80/72/64", distinct(3), distinct(0), distinct(1)); end
    checks++; if (cntc(2) !== 0) begin errors++; $display("FAIL t3_cidx2: got %0d want 0", cntc(2)); end
    checks++; if (qc.size() == 0 || qc[0] !== 3 || qc[qc.size()-1] !== 1) begin
      errors++; $display("FAIL t3_order: got first/last cidx wrong, want 3 then 1"); end
    checks++; if (done_cyc - last_pix !== 3) begin errors++; $display("FAIL t3_done_lat: got %0d want 3", done_cyc - last_pix); end
    checks++; if (m_c !== 1) begin errors++; $display("FAIL t3_cidx_hold: got %0d want 1", m_c); end
  endtask

  task automatic test_oe_stall;
    run(0, 50, -1, 1'b0);
    checks++; if (tmo !== 1'b0 || ndone !== 1) begin errors++; $display("FAIL t4_done: got tmo=%0d ndone=%0d want 0,1", tmo, ndone); end
    checks++; if (distinct(0) !== 24 || distinct(1) !== 8) begin errors++; $display("FAIL t4_pixels: got %0d/%0d want 24/8", distinct(0), distinct(1)); end
    checks++; if (outside(0, 0, 0, 7, 5, 1) + outside(1, 2, 2, 5, 3, 1) !== 0) begin errors++; $display("FAIL t4_border: got stray pixels want 0"); end
    checks++; if (!(done_cyc > t1_done)) begin errors++; $display("FAIL t4_slower: got %0d want > %0d", done_cyc, t1_done); end
  endtask

  task automatic test_abort;
    bit hit = 1'b0;
    int nd = 0, nb = 0;
    sel = 0;
    @(negedge clk); oe_v[0] = 1'b1; start_v[0] = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk); start_v[0] = 1'b0; #1;
      if (m_dr && m_c == 1) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL t4_reach_s1: got no shape-1 pixel want one"); end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (m_x !== 0 || m_y !== 0 || m_c !== 0) begin errors++; $display("FAIL t4_abort_out: got (%0d,%0d,%0d) want 0s", m_x, m_y, m_c); end
    checks++; if ({m_dr, m_bz, m_dn} !== 3'b000) begin errors++; $display("FAIL t4_abort_flags: got %b want 000", {m_dr, m_bz, m_dn}); end
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin @(negedge clk); #1; if (m_dn) nd++; if (m_bz) nb++; end
    checks++; if (nd !== 0 || nb !== 0) begin errors++; $display("FAIL t4_no_done: got done=%0d busy=%0d want 0,0", nd, nb); end
    run(0, 100, -1, 1'b0);
    checks++; if (qc.size() == 0 || qc[0] !== 0) begin errors++; $display("FAIL t4_restart_s0: got first cidx wrong want 0"); end
    checks++; if (distinct(0) !== 24 || distinct(1) !== 8 || ndone !== 1) begin
      errors++; $display("FAIL t4_restart_run: got %0d/%0d done=%0d want 24/8/1", distinct(0), distinct(1), ndone); end
  endtask

  task automatic test_corner;
    run(3, 100, -1, 1'b0);
    checks++; if (first_busy !== 0 || done_cyc - first_busy !== 2) begin
      errors++; $display("FAIL t5_degen_lat: got init=%0d done=%0d want 0,2", first_busy, done_cyc); end
    checks++; if (qx.size() !== 0 || ndone !== 1) begin errors++; $display("FAIL t5_degen_draw: got %0d pixels %0d done want 0,1", qx.size(), ndone); end
    run(3, 100, -1, 1'b1);
    checks++; if (ndone !== 2) begin errors++; $display("FAIL t5_start_held: got %0d done want 2", ndone); end
    repeat (6) @(negedge clk);
    run(0, 100, 10, 1'b0);
    checks++; if (ndone !== 1 || qx.size() !== t1_tot || distinct(0) !== 24) begin
      errors++; $display("FAIL t5_start_busy: got done=%0d pix=%0d/%0d want 1,%0d,24", ndone, qx.size(), distinct(0), t1_tot); end
  endtask

  task automatic test_scale;
    int mnx = 9999, mxx = -9999, mny = 9999, mxy = -9999;
    run(4, 100, -1, 1'b0);
    for (int i = 0; i < qx.size(); i++) if (qc[i] == 0) begin
      if (qx[i] < mnx) mnx = qx[i];
      if (qx[i] > mxx) mxx = qx[i];
      if (qy[i] < mny) mny = qy[i];
      if (qy[i] > mxy) mxy = qy[i];
    end
    checks++; if (mnx !== 0 || mny !== 0 || mxx !== 14 || mxy !== 10) begin
      errors++; $display("FAIL t5_scale_span: got (%0d,%0d)-(%0d,%0d) want (0,0)-(14,10)", mnx, mny, mxx, mxy); end
    checks++; if (distinct(0) !== 48 || distinct(1) !== 16) begin errors++; $display("FAIL t5_scale_pixels: got %0d/%0d want 48/16", distinct(0), distinct(1)); end
    checks++; if (outside(1, 4, 4, 10, 6, 1) !== 0) begin errors++; $display("FAIL t5_scale_s1: got %0d stray want 0", outside(1, 4, 4, 10, 6, 1)); end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin start_v[i] = 1'b0; oe_v[i] = 1'b1; end
    sel = 0;
    test_reset();
    test_outline();
    test_fill();
    test_colour_wrap();
    test_oe_stall();
    test_abort();
    test_corner();
    test_scale();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
